// File: rtl/button_debouncer.sv
// button_debouncer: synchronises and debounces a raw push-button into a pressed level,
// one-cycle press/release/long-press pulses and a toggle that flips on every press.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int LONG_CYCLES     = 12000000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic toggle_q
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(LONG_CYCLES);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, PRESS_WAIT, PRESSED, LONG_HELD, RELEASE_WAIT} state_t;
  state_t state;
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  logic [HW-1:0] hold;
  logic btn_s, from_long;
  assign btn_s = sync[1] ^ ACTIVE_LOW;
  // hold saturates at HOLD_LAST, so a glitch straddling the long threshold can't skip it
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync          <= {2{ACTIVE_LOW}};
      state         <= IDLE;
      cnt           <= '0;
      hold          <= '0;
      from_long     <= 1'b0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      toggle_q      <= 1'b0;
    end else begin
      sync          <= {sync[0], btn_raw};
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      case (state)
        IDLE:
          if (btn_s) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
          end
        PRESS_WAIT:
          if (!btn_s) state <= IDLE;
          else if (cnt == CNT_LAST) begin
            state       <= PRESSED;
            hold        <= '0;
            btn_level   <= 1'b1;
            press_pulse <= 1'b1;
            toggle_q    <= ~toggle_q;
          end else cnt <= cnt + 1'b1;
        PRESSED: begin
          hold <= hold + HW'(hold != HOLD_LAST);
          if (!btn_s) begin
            state     <= RELEASE_WAIT;
            cnt       <= '0;
            from_long <= 1'b0;
          end else if (hold == HOLD_LAST) begin
            state      <= LONG_HELD;
            long_pulse <= 1'b1;
          end
        end
        LONG_HELD:
          if (!btn_s) begin
            state     <= RELEASE_WAIT;
            cnt       <= '0;
            from_long <= 1'b1;
          end
        RELEASE_WAIT:
          if (btn_s) state <= from_long ? LONG_HELD : PRESSED;
          else if (cnt == CNT_LAST) begin
            state         <= IDLE;
            btn_level     <= 1'b0;
            release_pulse <= 1'b1;
          end else cnt <= cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_button_debouncer.sv
// tb_button_debouncer: scoreboard bench; stimulus queues expected pulses, a negedge monitor pops and compares.
module tb_button_debouncer;
  logic clk = 1'b0, rst_n = 1'b0, raw_a = 1'b1, raw_b = 1'b0;
  logic [1:0] lvl, prs, rel, lng, tgl;
  int cyc = 0, n_vec = 0, n_err = 0, m_kind;
  bit exp_tog = 1'b0;
  typedef struct {int dut; int kind; int at; bit lvl; bit tog;} evt_t;
  evt_t q[$];
  evt_t m_e;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  button_debouncer #(.DEBOUNCE_CYCLES(4), .LONG_CYCLES(20), .ACTIVE_LOW(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .btn_raw(raw_a), .btn_level(lvl[0]), .press_pulse(prs[0]),
    .release_pulse(rel[0]), .long_pulse(lng[0]), .toggle_q(tgl[0]));
  button_debouncer #(.DEBOUNCE_CYCLES(4), .LONG_CYCLES(20), .ACTIVE_LOW(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .btn_raw(raw_b), .btn_level(lvl[1]), .press_pulse(prs[1]),
    .release_pulse(rel[1]), .long_pulse(lng[1]), .toggle_q(tgl[1]));
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic expect_evt(input int d, input int k, input int at, input bit l, input bit t);
    q.push_back('{d, k, at, l, t});
  endtask
  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  // kind: 0 = press, 1 = release, 2 = long
  always @(negedge clk)
    for (int d = 0; d < 2; d++)
      if (prs[d] | rel[d] | lng[d]) begin
        m_kind = prs[d] ? 0 : rel[d] ? 1 : 2;
        check($sformatf("dut%0d pulses exclusive", d), int'(prs[d]) + int'(rel[d]) + int'(lng[d]), 1);
        if (q.size() == 0) check($sformatf("dut%0d unexpected pulse kind", d), m_kind, -1);
        else begin
          m_e = q.pop_front();
          check("pulse dut*10+kind", d * 10 + m_kind, m_e.dut * 10 + m_e.kind);
          check("pulse cycle", cyc, m_e.at);
          check("level at pulse", int'(lvl[d]), int'(m_e.lvl));
          check("toggle at pulse", int'(tgl[d]), int'(m_e.tog));
        end
      end
  initial begin
    int e;
    #1;
    check("reset outputs a", {lvl[0], prs[0], rel[0], lng[0], tgl[0]}, 0);
    check("reset outputs b", {lvl[1], prs[1], rel[1], lng[1], tgl[1]}, 0);
    step(3);
    rst_n = 1'b1;
    step(5);
    // clean long press
    e = cyc; raw_a = 1'b0; exp_tog = ~exp_tog;
    expect_evt(0, 0, e + 7, 1'b1, exp_tog);
    expect_evt(0, 2, e + 27, 1'b1, exp_tog);
    step(20);
    check("s1 level held", lvl[0], 1);
    step(20);
    raw_a = 1'b1;
    expect_evt(0, 1, e + 47, 1'b0, exp_tog);
    step(15);
    // short bounce rejected
    raw_a = 1'b0;
    step(3);
    raw_a = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step(1);
      check("s2 level stays low", lvl[0], 0);
    end
    check("s2 toggle unchanged", tgl[0], exp_tog);
    // release glitch while pressed delays long by 2
    e = cyc; raw_a = 1'b0; exp_tog = ~exp_tog;
    expect_evt(0, 0, e + 7, 1'b1, exp_tog);
    step(19);
    raw_a = 1'b1;
    step(2);
    raw_a = 1'b0;
    expect_evt(0, 2, e + 29, 1'b1, exp_tog);
    for (int i = 0; i < 8; i++) begin
      step(1);
      check("s3 level through glitch", lvl[0], 1);
    end
    step(11);
    raw_a = 1'b1;
    expect_evt(0, 1, e + 47, 1'b0, exp_tog);
    step(15);
    // four short presses
    for (int k = 0; k < 4; k++) begin
      e = cyc; raw_a = 1'b0; exp_tog = ~exp_tog;
      expect_evt(0, 0, e + 7, 1'b1, exp_tog);
      step(10);
      raw_a = 1'b1;
      expect_evt(0, 1, e + 17, 1'b0, exp_tog);
      step(10);
    end
    step(10);
    check("s4 final toggle", tgl[0], exp_tog);
    // async reset mid PRESS_WAIT, then while PRESSED
    raw_a = 1'b0;
    step(4);
    rst_n = 1'b0;
    #1;
    check("s5 reset in press_wait", {lvl[0], prs[0], rel[0], lng[0], tgl[0]}, 0);
    step(2);
    rst_n = 1'b1; e = cyc; exp_tog = 1'b1;
    expect_evt(0, 0, e + 7, 1'b1, exp_tog);
    for (int i = 0; i < 6; i++) begin
      step(1);
      check("s5 no early press", {prs[0], lvl[0]}, 0);
    end
    step(3);
    check("s5 level before reset", {lvl[0], tgl[0]}, 3);
    #1 rst_n = 1'b0;
    #1;
    check("s5 async reset clears", {lvl[0], prs[0], rel[0], lng[0], tgl[0]}, 0);
    raw_a = 1'b1;
    step(2);
    rst_n = 1'b1; exp_tog = 1'b0;
    step(20);
    // active-high instance
    check("s6 b idle", {lvl[1], tgl[1]}, 0);
    e = cyc; raw_b = 1'b1;
    expect_evt(1, 0, e + 7, 1'b1, 1'b1);
    step(10);
    raw_b = 1'b0;
    expect_evt(1, 1, e + 17, 1'b0, 1'b1);
    step(15);
    check("s6 a untouched", {lvl[0], tgl[0]}, 0);
    check("scoreboard drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Cleans one raw mechanical push-button input and turns it into a stable level and single-cycle event pulses: press, release and long-press.
- Also provides a toggle state that flips on every confirmed press.
- Sits directly upstream of the LED toggling/pattern logic and replaces the free-running 1 s timer as that stage's toggle source.
- Board clock is 12 MHz.

Parameters:
- DEBOUNCE_CYCLES, 120000: consecutive stable cycles required to accept a level change (10 ms at 12 MHz). Legal range ≥2.
- LONG_CYCLES, 12000000: cycles held in the pressed state before long_pulse fires (1 s at 12 MHz). Must be > DEBOUNCE_CYCLES.
- ACTIVE_LOW, 1: 1 means btn_raw=0 is "pressed"; 0 means btn_raw=1 is "pressed".

Ports:
- clk  input  1  system clock, 12 MHz.
- rst_n  input  1  asynchronous active-low reset.
- btn_raw  input  1  raw pad input; asynchronous and bouncy.
- btn_level  output  1  debounced pressed level; 1 = pressed.
- press_pulse  output  1  one-cycle pulse on each confirmed press.
- release_pulse  output  1  one-cycle pulse on each confirmed release.
- long_pulse  output  1  one-cycle pulse when a press has been held LONG_CYCLES.
- toggle_q  output  1  flips on every press_pulse.

Behaviour:
- Reset (one clock; reset is asynchronous and active-low):
  - rst_n=0 clears immediately, independent of clk: state=IDLE, all counters 0, btn_level=0, press_pulse=0, release_pulse=0, long_pulse=0, toggle_q=0.
  - Both synchronizer flops reset to the released pad level (1 if ACTIVE_LOW, else 0).
- Input path:
  - 2-flop synchronizer on btn_raw, then polarity normalisation to btn_s (1 = pressed).
  - btn_s first reflects a pad change on the 2nd rising edge after the change.
- State machine and debounce counter cnt:
  - IDLE: btn_level=0. On btn_s=1: go to PRESS_WAIT, cnt=0.
  - PRESS_WAIT: if btn_s=0, return to IDLE with no pulse (bounce rejected). Else cnt+1. On the edge where cnt==DEBOUNCE_CYCLES-1 with btn_s=1: go to PRESSED, hold=0.
  - PRESSED: btn_level=1 and hold+1 each cycle. On btn_s=0: go to RELEASE_WAIT, cnt=0, hold frozen, remember "from PRESSED". If hold==LONG_CYCLES-1 with btn_s=1: go to LONG_HELD.
  - LONG_HELD: btn_level=1. On btn_s=0: go to RELEASE_WAIT, cnt=0, remember "from LONG_HELD".
  - RELEASE_WAIT: btn_level stays 1. If btn_s=1, return to the remembered state with no pulse and hold resuming from its frozen value (glitch rejected). Else cnt+1. On cnt==DEBOUNCE_CYCLES-1 with btn_s=0: go to IDLE.
- Pulses (all registered, high for exactly one cycle):
  - press_pulse: first cycle in PRESSED.
  - long_pulse: first cycle in LONG_HELD. Fires at most once per press; no auto-repeat.
  - release_pulse: first cycle back in IDLE after RELEASE_WAIT.
  - Pulses are mutually exclusive by construction.
  - toggle_q updates in the same cycle press_pulse is high.
- Latency:
  - Pad change at edge 0, held stable: btn_s high at edge 2, PRESS_WAIT entered at edge 3, press_pulse and btn_level high from edge DEBOUNCE_CYCLES+3.
  - Release follows the same rule: release_pulse high and btn_level low from edge DEBOUNCE_CYCLES+3 after the pad release.
  - long_pulse fires LONG_CYCLES cycles after press_pulse, plus any cycles spent in rejected release glitches.
- Widths:
  - cnt is $clog2(DEBOUNCE_CYCLES) bits; hold is $clog2(LONG_CYCLES) bits.
  - Neither counter wraps: both are reset on state entry and compared with ==.
  - In LONG_HELD hold stops counting.
- Reset mid-operation:
  - Any state collapses to IDLE with all outputs 0 in the same cycle.
  - After rst_n release, a button still held is treated as a new press and must be fully debounced; the synchronizer reset value guarantees no spurious pulse.

Test Plan (DEBOUNCE_CYCLES=4, LONG_CYCLES=20, ACTIVE_LOW=1):
1. btn_raw 1→0 at edge 10, held 40 cycles, then 0→1 → press_pulse and toggle_q 0→1 at edge 17; btn_level 1 over edges 17..56; release_pulse at edge 57 (pad released at edge 50); long_pulse at edge 37 only.
2. btn_raw low for 3 cycles, then high → no pulses; btn_level stays 0; toggle_q unchanged.
3. Press held 12 cycles past press_pulse, 2-cycle high glitch, then held → no release_pulse, no second press_pulse; btn_level stays 1; long_pulse delayed by 2 cycles versus scenario 1.
4. Four clean presses of 10 cycles, separated by 10 released cycles → 4 press_pulse, 4 release_pulse, 0 long_pulse; toggle_q sequence 0→1→0→1→0.
5. rst_n driven low asynchronously mid-PRESS_WAIT and again while PRESSED → all outputs 0 before the next clk edge. With btn_raw held low through rst_n release at edge R: press_pulse at R+7, never earlier.
6. ACTIVE_LOW=0 build, btn_raw held 0 from reset → no pulses for 100 cycles; btn_raw 0→1 at edge 10 → press_pulse at edge 17.
